// File: rtl/flash_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : flash_cmd_sequencer_if
// Brief    : Host request, target ACK and DataIO control bundle for the
//            flash command sequencer.
// Revision : 1.0
// ============================================================================
interface flash_cmd_sequencer_if;
  logic       Start;
  logic [1:0] Op;
  logic       AckIn;
  logic       Busy;
  logic       Done;
  logic       Error;
  logic       SelData;
  logic       SelAA;
  logic       Sel55;
  logic       SelB0;
  logic       SelC0;
  logic       SelD0;
  logic       SelE0;
  logic       Sel00;
  logic       EnDataOut;
  logic       EnDataIn;
  logic       LoadShift;
  logic       CaptureIn;

  modport master (
    output Start, Op, AckIn,
    input  Busy, Done, Error,
    input  SelData, SelAA, Sel55, SelB0, SelC0, SelD0, SelE0, Sel00,
    input  EnDataOut, EnDataIn, LoadShift, CaptureIn
  );

  modport slave (
    input  Start, Op, AckIn,
    output Busy, Done, Error,
    output SelData, SelAA, Sel55, SelB0, SelC0, SelD0, SelE0, Sel00,
    output EnDataOut, EnDataIn, LoadShift, CaptureIn
  );
endinterface
`default_nettype wire

// File: rtl/flash_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : flash_cmd_sequencer
// Brief    : Steps through flash unlock/command byte slots, gating DataIO
//            select/enable and shift load/capture, with per-byte ACK checks.
// Revision : 1.0
// ============================================================================
module flash_cmd_sequencer #(
  parameter int BIT_COUNT = 8
) (
  input wire logic            SCL,
  input wire logic            Reset,
  flash_cmd_sequencer_if.slave bus
);

  localparam int c_cntW = $clog2(BIT_COUNT + 1);
  localparam logic [c_cntW-1:0] c_lastBit = c_cntW'(BIT_COUNT - 1);
  localparam logic [c_cntW-1:0] c_recvEnd = c_cntW'(BIT_COUNT);

  localparam logic [1:0] c_opRead    = 2'd0;
  localparam logic [1:0] c_opProgram = 2'd1;
  localparam logic [1:0] c_opErase   = 2'd2;

  // Select vector order: {Data, AA, 55, B0, C0, D0, E0, 00}
  localparam logic [7:0] c_selData = 8'h80;
  localparam logic [7:0] c_selAA   = 8'h40;
  localparam logic [7:0] c_sel55   = 8'h20;
  localparam logic [7:0] c_selB0   = 8'h10;
  localparam logic [7:0] c_selC0   = 8'h08;
  localparam logic [7:0] c_selD0   = 8'h04;
  localparam logic [7:0] c_selE0   = 8'h02;
  localparam logic [7:0] c_sel00   = 8'h01;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_ACK   = 3'd3,
    S_RECV  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              r_state;
  logic [1:0]          r_op;
  logic [1:0]          r_step;
  logic [c_cntW-1:0]   r_bitCnt;
  logic [7:0]          r_sel;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic                r_enDataOut;
  logic                r_enDataIn;
  logic                r_loadShift;
  logic                r_captureIn;

  function automatic logic [7:0] selFor(input logic [1:0] op, input logic [1:0] step);
    logic [7:0] s;
    case (step)
      2'd0:    s = c_selAA;
      2'd1:    s = c_sel55;
      2'd2: begin
        case (op)
          c_opRead:    s = c_sel00;
          c_opProgram: s = c_selB0;
          c_opErase:   s = c_selC0;
          default:     s = c_selE0;
        endcase
      end
      default: s = (op == c_opProgram) ? c_selData : c_selD0;
    endcase
    return s;
  endfunction

  // READ and SUSPEND send three bytes, PROGRAM and ERASE send four.
  function automatic logic [1:0] lastStep(input logic [1:0] op);
    return (op == c_opProgram || op == c_opErase) ? 2'd3 : 2'd2;
  endfunction

  // Outputs are assigned alongside the transition so they track the new state.
  always_ff @(posedge SCL) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_op        <= c_opRead;
      r_step      <= 2'd0;
      r_bitCnt    <= '0;
      r_sel       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_enDataOut <= 1'b0;
      r_enDataIn  <= 1'b0;
      r_loadShift <= 1'b0;
      r_captureIn <= 1'b0;
    end else begin
      r_loadShift <= 1'b0;
      r_captureIn <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.Start) begin
            r_state     <= S_LOAD;
            r_op        <= bus.Op;
            r_step      <= 2'd0;
            r_busy      <= 1'b1;
            r_error     <= 1'b0;
            r_sel       <= selFor(bus.Op, 2'd0);
            r_enDataOut <= 1'b1;
            r_loadShift <= 1'b1;
          end
        end
        S_LOAD: begin
          r_state  <= S_SHIFT;
          r_bitCnt <= '0;
        end
        S_SHIFT: begin
          if (r_bitCnt == c_lastBit) begin
            r_state     <= S_ACK;
            r_sel       <= '0;
            r_enDataOut <= 1'b0;
          end else begin
            r_bitCnt <= r_bitCnt + 1'b1;
          end
        end
        S_ACK: begin
          if (bus.AckIn) begin
            r_state <= S_DONE;
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (r_step != lastStep(r_op)) begin
            r_state     <= S_LOAD;
            r_step      <= r_step + 2'd1;
            r_sel       <= selFor(r_op, r_step + 2'd1);
            r_enDataOut <= 1'b1;
            r_loadShift <= 1'b1;
          end else if (r_op == c_opRead) begin
            r_state    <= S_RECV;
            r_bitCnt   <= '0;
            r_enDataIn <= 1'b1;
          end else begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_RECV: begin
          // BIT_COUNT shift cycles followed by one capture cycle.
          if (r_bitCnt == c_recvEnd) begin
            r_state    <= S_DONE;
            r_enDataIn <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
          end else begin
            r_bitCnt <= r_bitCnt + 1'b1;
            if (r_bitCnt == c_lastBit) begin
              r_captureIn <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.Busy      = r_busy;
  assign bus.Done      = r_done;
  assign bus.Error     = r_error;
  assign bus.SelData   = r_sel[7];
  assign bus.SelAA     = r_sel[6];
  assign bus.Sel55     = r_sel[5];
  assign bus.SelB0     = r_sel[4];
  assign bus.SelC0     = r_sel[3];
  assign bus.SelD0     = r_sel[2];
  assign bus.SelE0     = r_sel[1];
  assign bus.Sel00     = r_sel[0];
  assign bus.EnDataOut = r_enDataOut;
  assign bus.EnDataIn  = r_enDataIn;
  assign bus.LoadShift = r_loadShift;
  assign bus.CaptureIn = r_captureIn;

endmodule
`default_nettype wire

// File: tb/tb_flash_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_flash_cmd_sequencer
// Brief    : Directed stimulus with a queued scoreboard of slot/done events.
// Revision : 1.0
// ============================================================================
module tb_flash_cmd_sequencer;

  localparam int BIT_COUNT = 8;

  localparam logic [7:0] c_selData = 8'h80;
  localparam logic [7:0] c_selAA   = 8'h40;
  localparam logic [7:0] c_sel55   = 8'h20;
  localparam logic [7:0] c_selB0   = 8'h10;
  localparam logic [7:0] c_selC0   = 8'h08;
  localparam logic [7:0] c_selD0   = 8'h04;
  localparam logic [7:0] c_selE0   = 8'h02;
  localparam logic [7:0] c_sel00   = 8'h01;

  localparam int c_kLoad = 0;
  localparam int c_kCap  = 1;
  localparam int c_kDone = 2;

  typedef struct {
    int         kind;
    logic [7:0] sel;
    int         cyc;
    logic       err;
    int         busy;
  } ev_t;

  logic SCL;
  logic Reset;
  int   cyc;
  int   base;
  int   nackCycle;
  int   nTests;
  int   nFail;
  ev_t  q[$];

  flash_cmd_sequencer_if bus ();

  flash_cmd_sequencer #(.BIT_COUNT(BIT_COUNT)) dut (
    .SCL   (SCL),
    .Reset (Reset),
    .bus   (bus)
  );

  initial SCL = 1'b0;
  always #5 SCL = ~SCL;

  initial cyc = 0;
  always @(posedge SCL) cyc <= cyc + 1;

  always @(negedge SCL) bus.AckIn = (cyc == nackCycle);

  function automatic logic [7:0] selNow();
    return {bus.SelData, bus.SelAA, bus.Sel55, bus.SelB0,
            bus.SelC0, bus.SelD0, bus.SelE0, bus.Sel00};
  endfunction

  function automatic logic [14:0] allOut();
    return {bus.Busy, bus.Done, bus.Error, selNow(),
            bus.EnDataOut, bus.EnDataIn, bus.LoadShift, bus.CaptureIn};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nTests++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic pushLoad(input logic [7:0] sel, input int off);
    ev_t e;
    e.kind = c_kLoad; e.sel = sel; e.cyc = base + off; e.err = 1'b0; e.busy = 0;
    q.push_back(e);
  endtask

  task automatic pushCap(input int off);
    ev_t e;
    e.kind = c_kCap; e.sel = '0; e.cyc = base + off; e.err = 1'b0; e.busy = 0;
    q.push_back(e);
  endtask

  task automatic pushDone(input int off, input logic err, input int busy);
    ev_t e;
    e.kind = c_kDone; e.sel = '0; e.cyc = base + off; e.err = err; e.busy = busy;
    q.push_back(e);
  endtask

  // Drives Start for the coming edge; caller pushes expectations, then endStart.
  task automatic beginStart(input logic [1:0] op);
    @(negedge SCL);
    base      = cyc + 1;
    bus.Op    = op;
    bus.Start = 1'b1;
  endtask

  task automatic endStart();
    @(negedge SCL);
    bus.Start = 1'b0;
  endtask

  task automatic waitCyc(input int target);
    for (int i = 0; i < 1000 && cyc < target; i++) @(negedge SCL);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge SCL);
    chk(name, q.size(), 0);
    repeat (4) @(negedge SCL);
    chk({name, "_idleBusy"}, int'(bus.Busy), 0);
  endtask

  // Monitor: invariants every cycle, scoreboard pops on LoadShift/CaptureIn/Done.
  initial begin
    int         busyCnt;
    int         enInCnt;
    int         outRun;
    logic [7:0] curSel;
    logic [7:0] s;
    ev_t        e;
    busyCnt = 0; enInCnt = 0; outRun = 0; curSel = '0;
    forever begin
      @(posedge SCL);
      #1;
      s = selNow();
      if (Reset) begin
        busyCnt = 0; enInCnt = 0; outRun = 0;
      end else begin
        chk("invariant", int'(($countones(s) <= 1) && !(bus.EnDataOut && bus.EnDataIn)), 1);
        if (bus.Busy) busyCnt++;
        if (bus.EnDataIn) enInCnt++;
        if (bus.EnDataOut) begin
          outRun++;
          if (bus.LoadShift) curSel = s;
          else chk("selHold", int'(s), int'(curSel));
        end else if (outRun != 0) begin
          chk("txSlotLen", outRun, BIT_COUNT + 1);
          outRun = 0;
        end
        if (bus.LoadShift || bus.CaptureIn || bus.Done) begin
          if (q.size() == 0) begin
            chk("unexpectedEvent", int'({bus.LoadShift, bus.CaptureIn, bus.Done}), 0);
          end else begin
            e = q.pop_front();
            chk("evCycle", cyc, e.cyc);
            if (bus.LoadShift) begin
              chk("evKindLoad", c_kLoad, e.kind);
              chk("loadSel", int'(s), int'(e.sel));
              chk("loadErr", int'(bus.Error), 0);
              chk("loadBusy", int'(bus.Busy), 1);
            end else if (bus.CaptureIn) begin
              chk("evKindCap", c_kCap, e.kind);
              chk("recvLen", enInCnt, BIT_COUNT + 1);
              chk("capOutEn", int'(bus.EnDataOut), 0);
            end else begin
              chk("evKindDone", c_kDone, e.kind);
              chk("doneErr", int'(bus.Error), int'(e.err));
              chk("doneBusy", int'(bus.Busy), 0);
              chk("busyLen", busyCnt, e.busy);
            end
          end
        end
        if (!bus.Busy) busyCnt = 0;
        if (!bus.EnDataIn) enInCnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nTests = 0; nFail = 0; nackCycle = -1; base = 0;
    bus.Start = 1'b0; bus.Op = 2'd0;
    Reset = 1'b1;
    repeat (3) @(negedge SCL);
    chk("resetOutputs", int'(allOut()), 0);
    Reset = 1'b1; bus.Start = 1'b1;
    @(negedge SCL);
    Reset = 1'b0; bus.Start = 1'b0;
    repeat (2) @(negedge SCL);
    chk("startDuringReset", int'(allOut()), 0);

    // ERASE, all ACKs
    beginStart(2'd2);
    pushLoad(c_selAA, 0); pushLoad(c_sel55, 10); pushLoad(c_selC0, 20); pushLoad(c_selD0, 30);
    pushDone(40, 1'b0, 40);
    endStart();
    drain("erase");

    // SUSPEND, NACK on the second byte
    beginStart(2'd3);
    nackCycle = base + 19;
    pushLoad(c_selAA, 0); pushLoad(c_sel55, 10);
    pushDone(20, 1'b1, 20);
    endStart();
    drain("suspendNack");
    nackCycle = -1;
    chk("errorSticky", int'(bus.Error), 1);

    // PROGRAM clears Error on acceptance
    beginStart(2'd1);
    pushLoad(c_selAA, 0); pushLoad(c_sel55, 10); pushLoad(c_selB0, 20); pushLoad(c_selData, 30);
    pushDone(40, 1'b0, 40);
    endStart();
    drain("program");

    // READ with receive slot
    beginStart(2'd0);
    pushLoad(c_selAA, 0); pushLoad(c_sel55, 10); pushLoad(c_sel00, 20);
    pushCap(38);
    pushDone(39, 1'b0, 39);
    endStart();
    drain("read");

    // ERASE with Start re-pulsed and Op changed mid-operation and in DONE
    beginStart(2'd2);
    pushLoad(c_selAA, 0); pushLoad(c_sel55, 10); pushLoad(c_selC0, 20); pushLoad(c_selD0, 30);
    pushDone(40, 1'b0, 40);
    endStart();
    bus.Op = 2'd0;
    waitCyc(base + 5);  bus.Start = 1'b1; @(negedge SCL); bus.Start = 1'b0; bus.Op = 2'd3;
    waitCyc(base + 15); bus.Start = 1'b1; @(negedge SCL); bus.Start = 1'b0; bus.Op = 2'd1;
    waitCyc(base + 40); bus.Start = 1'b1; @(negedge SCL); bus.Start = 1'b0;
    drain("eraseRestart");

    // Reset during SHIFT of byte 2
    beginStart(2'd2);
    pushLoad(c_selAA, 0); pushLoad(c_sel55, 10);
    endStart();
    waitCyc(base + 13);
    Reset = 1'b1;
    @(negedge SCL);
    chk("abortOutputs", int'(allOut()), 0);
    Reset = 1'b0;
    drain("abort");

    // SUSPEND after abort, full sequence
    beginStart(2'd3);
    pushLoad(c_selAA, 0); pushLoad(c_sel55, 10); pushLoad(c_selE0, 20);
    pushDone(30, 1'b0, 30);
    endStart();
    drain("suspend");
    chk("finalError", int'(bus.Error), 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/flash_cmd_sequencer.md
Name: flash_cmd_sequencer

Overview:
Command sequencer that drives the DataIO byte-select/enable lines to issue flash command sequences over the serial bus. Accepts a one-shot operation request, steps through the unlock/command byte list one byte slot at a time, and gates shift-register load/capture. Checks the target ACK after every transmitted byte. Reports Busy/Done/Error to the host-side control FSM.

Parameters:
BIT_COUNT, 8, SCL cycles per byte shift phase (data bits per byte)

Ports:
SCL  in  1  system clock; all state updates on rising edge
Reset  in  1  synchronous, active-high reset
Start  in  1  operation request; sampled only in IDLE
Op  in  2  operation: 0=READ, 1=PROGRAM, 2=ERASE, 3=SUSPEND
AckIn  in  1  target acknowledge, sampled in ACK state; 0=ACK, 1=NACK
Busy  out  1  high from the cycle after Start is accepted until Done
Done  out  1  single-cycle completion pulse (success or error)
Error  out  1  NACK seen; sticky until next accepted Start or Reset
SelData, SelAA, Sel55, SelB0, SelC0, SelD0, SelE0, Sel00  out  1 each  one-hot DataIO byte select; all 0 outside transmit slots
EnDataOut  out  1  DataIO output enable
EnDataIn  out  1  DataIO input enable
LoadShift  out  1  load DataIO byte into shift register (first cycle of transmit slot)
CaptureIn  out  1  latch ShiftRegIn (last cycle of receive slot)

Behaviour:
- Reset: state=IDLE. Busy, Done, Error, all Sel*, EnDataOut, EnDataIn, LoadShift, CaptureIn = 0. Reset mid-operation aborts immediately; no partial cleanup.
- All outputs are registered/Moore, decoded from state, step index, and bit counter; no combinational path from Start or AckIn to any output.
- Byte lists (Op latched on Start acceptance; later Op changes ignored):
  - READ: AA, 55, 00, then receive slot
  - PROGRAM: AA, 55, B0, Data (SelData)
  - ERASE: AA, 55, C0, D0
  - SUSPEND: AA, 55, E0
- States:
  - IDLE: Start=1 -> LOAD, step=0, Busy=1, Error cleared.
  - LOAD: 1 cycle. Selected Sel*=1, EnDataOut=1, LoadShift=1 -> SHIFT, bitcnt=0.
  - SHIFT: BIT_COUNT cycles. Sel* held, EnDataOut=1. At bitcnt=BIT_COUNT-1 -> ACK.
  - ACK: 1 cycle. Sel*=0, EnDataOut=0. Sample AckIn.
    - AckIn=1 -> DONE with Error=1.
    - Else, if more transmit bytes -> LOAD with step+1.
    - Else, if Op=READ -> RECV.
    - Else -> DONE.
  - RECV: BIT_COUNT cycles with EnDataIn=1, then 1 cycle with EnDataIn=1 and CaptureIn=1 -> DONE.
  - DONE: 1 cycle. Done=1, Busy=0 -> IDLE.
- Transmit slot = BIT_COUNT+2 cycles (10 by default). Receive slot = BIT_COUNT+1 cycles (9). No idle gap between slots.
- Start while Busy or in DONE is ignored (not queued). Start in the same cycle as Reset is ignored.
- EnDataOut and EnDataIn are never both 1. At most one Sel* is 1 in any cycle.
- Error stays 1 after DONE until the next accepted Start.

Test Plan:
1. Reset, then Start=1 with Op=2 (ERASE) for 1 cycle, AckIn=0 -> Sel* sequence AA, 55, C0, D0 in 10-cycle slots; LoadShift pulses at slot offsets 0/10/20/30; Busy=1 for 40 cycles; Done pulses at cycle 41; Error=0.
2. PROGRAM, AckIn=0 -> Sel sequence AA, 55, B0, then SelData on slot 4; Done after 40 busy cycles.
3. READ -> AA, 55, 00 (30 cycles), then EnDataIn=1 for 9 cycles with CaptureIn on the 9th and EnDataOut=0 throughout; Done at cycle 40.
4. SUSPEND with AckIn=1 during the 2nd ACK cycle -> Sel55 slot completes, no SelE0; Done and Error=1 at cycle 21; Error still 1 in IDLE; next Start clears it.
5. Start pulsed again mid-ERASE, and Op changed mid-operation -> sequence unchanged and no second operation started. Reset asserted during the SHIFT of byte 2 -> all outputs 0 on the next cycle, state IDLE.
6. Every cycle of tests 1–5: assert Sel* one-hot-or-zero and that EnDataOut and EnDataIn are never both high.
